mc_control: RTL



---
 rtl/mips_ctl_pkg.sv | 119 +++++++++++
 rtl/mc_decode.sv | 69 ++++++
 rtl/mc_control.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: states, ALU op codes,
// datapath mux encodings, opcode/funct/rt values and instruction classes.
package mips_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_MULDIV = 3'd6
  } state_t;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_SLL  = 6'b000010;
  localparam logic [5:0] ALU_SRL  = 6'b000100;
  localparam logic [5:0] ALU_SRA  = 6'b000110;
  localparam logic [5:0] ALU_OR   = 6'b001000;
  localparam logic [5:0] ALU_AND  = 6'b010000;
  localparam logic [5:0] ALU_NOR  = 6'b011000;
  localparam logic [5:0] ALU_XOR  = 6'b100000;
  localparam logic [5:0] ALU_SLT  = 6'b101001;
  localparam logic [5:0] ALU_SLTU = 6'b110001;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REGA   = 2'd3;

  localparam logic [1:0] SRC_B_REGB    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL     = 6'b000000;
  localparam logic [5:0] F_SRL     = 6'b000010;
  localparam logic [5:0] F_SRA     = 6'b000011;
  localparam logic [5:0] F_SLLV    = 6'b000100;
  localparam logic [5:0] F_SRLV    = 6'b000110;
  localparam logic [5:0] F_SRAV    = 6'b000111;
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_JALR    = 6'b001001;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_MFHI    = 6'b010000;
  localparam logic [5:0] F_MTHI    = 6'b010001;
  localparam logic [5:0] F_MFLO    = 6'b010010;
  localparam logic [5:0] F_MTLO    = 6'b010011;
  localparam logic [5:0] F_MULT    = 6'b011000;
  localparam logic [5:0] F_MULTU   = 6'b011001;
  localparam logic [5:0] F_DIV     = 6'b011010;
  localparam logic [5:0] F_DIVU    = 6'b011011;
  localparam logic [5:0] F_ADD     = 6'b100000;
  localparam logic [5:0] F_ADDU    = 6'b100001;
  localparam logic [5:0] F_SUB     = 6'b100010;
  localparam logic [5:0] F_SUBU    = 6'b100011;
  localparam logic [5:0] F_AND     = 6'b100100;
  localparam logic [5:0] F_OR      = 6'b100101;
  localparam logic [5:0] F_XOR     = 6'b100110;
  localparam logic [5:0] F_NOR     = 6'b100111;
  localparam logic [5:0] F_SLT     = 6'b101010;
  localparam logic [5:0] F_SLTU    = 6'b101011;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_RALU    = 4'd1,
    CLS_IALU    = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_JUMP    = 4'd6,
    CLS_JR      = 4'd7,
    CLS_MULDIV  = 4'd8,
    CLS_MFHILO  = 4'd9,
    CLS_MTHILO  = 4'd10,
    CLS_SYSCALL = 4'd11
  } instr_class_t;

  localparam int CNT_W = 5;

endpackage

// File: rtl/mc_decode.sv
// Combinational classification of the IR op/funct/rt fields into an instruction
// class plus the ALU op, immediate extension and link flag it needs.
module mc_decode
  import mips_ctl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  input  logic [4:0]   rt,
  output instr_class_t cls,
  output logic [5:0]   alu_op,
  output logic         sign_ext,
  output logic         link,
  output logic         illegal
);

  always_comb begin
    cls      = CLS_ILLEGAL;
    alu_op   = ALU_ADD;
    sign_ext = 1'b1;
    link     = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SLLV: begin cls = CLS_RALU; alu_op = ALU_SLL; end
          F_SRL, F_SRLV: begin cls = CLS_RALU; alu_op = ALU_SRL; end
          F_SRA, F_SRAV: begin cls = CLS_RALU; alu_op = ALU_SRA; end
          F_ADD, F_ADDU: begin cls = CLS_RALU; alu_op = ALU_ADD; end
          F_SUB, F_SUBU: begin cls = CLS_RALU; alu_op = ALU_SUB; end
          F_AND:         begin cls = CLS_RALU; alu_op = ALU_AND; end
          F_OR:          begin cls = CLS_RALU; alu_op = ALU_OR;  end
          F_XOR:         begin cls = CLS_RALU; alu_op = ALU_XOR; end
          F_NOR:         begin cls = CLS_RALU; alu_op = ALU_NOR; end
          F_SLT:         begin cls = CLS_RALU; alu_op = ALU_SLT; end
          F_SLTU:        begin cls = CLS_RALU; alu_op = ALU_SLTU; end
          F_JR:          cls = CLS_JR;
          F_JALR:        begin cls = CLS_JR; link = 1'b1; end
          F_SYSCALL:     cls = CLS_SYSCALL;
          F_MFHI, F_MFLO: cls = CLS_MFHILO;
          F_MTHI, F_MTLO: cls = CLS_MTHILO;
          F_MULT, F_MULTU, F_DIV, F_DIVU: cls = CLS_MULDIV;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:     begin cls = CLS_BRANCH; alu_op = ALU_SUB; end
          RT_BLTZAL, RT_BGEZAL: begin cls = CLS_BRANCH; alu_op = ALU_SUB; link = 1'b1; end
          default: ;
        endcase
      end
      OP_J:   cls = CLS_JUMP;
      OP_JAL: begin cls = CLS_JUMP; link = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin cls = CLS_BRANCH; alu_op = ALU_SUB; end
      OP_ADDI, OP_ADDIU: begin cls = CLS_IALU; alu_op = ALU_ADD; end
      OP_SLTI:  begin cls = CLS_IALU; alu_op = ALU_SLT; end
      OP_SLTIU: begin cls = CLS_IALU; alu_op = ALU_SLTU; end
      // Logical immediates zero-extend.
      OP_ANDI:  begin cls = CLS_IALU; alu_op = ALU_AND; sign_ext = 1'b0; end
      OP_ORI:   begin cls = CLS_IALU; alu_op = ALU_OR;  sign_ext = 1'b0; end
      OP_XORI:  begin cls = CLS_IALU; alu_op = ALU_XOR; sign_ext = 1'b0; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: cls = CLS_LOAD;
      OP_SB, OP_SH, OP_SW: cls = CLS_STORE;
      default: ;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM sequencing fetch/decode/execute/memory/writeback for the
// shared MIPS datapath, with memory-ready stalls and a fixed mul/div latency.
//
// state  | meaning
// IDLE   | after reset, one cycle before the first fetch
// FETCH  | read instruction at PC, PC+4 on ready
// DECODE | classify IR, precompute branch target
// EXEC   | ALU op / branch / jump / link, by class
// MEM    | load or store data access, stalls on ready
// WB     | register file or HI/LO write
// MULDIV | wait MULDIV_LAT cycles, then write HI/LO
module mc_control
  import mips_ctl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT  = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] instr_op_ctl_i,
  input  logic [5:0] instr_funct_ctl_i,
  input  logic [4:0] instr_rt_ctl_i,
  input  logic       mem_ready_ctl_i,
  output logic       pc_wr_ctl_o,
  output logic       ir_wr_ctl_o,
  output logic       iord_ctl_o,
  output logic       mem_read_ctl_o,
  output logic       mem_wr_ctl_o,
  output logic       alu_src_a_ctl_o,
  output logic [1:0] alu_src_b_ctl_o,
  output logic [5:0] alu_op_ctl_o,
  output logic       sign_ext_ctl_o,
  output logic [1:0] pc_src_ctl_o,
  output logic       branch_ctl_o,
  output logic [1:0] reg_dst_ctl_o,
  output logic [1:0] mem_to_reg_ctl_o,
  output logic       reg_wr_ctl_o,
  output logic       hilo_wr_ctl_o,
  output logic       illegal_ctl_o,
  output logic [2:0] state_ctl_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  instr_class_t       cls;
  logic [5:0]         dec_alu_op;
  logic               dec_sign_ext, dec_link, dec_illegal;
  logic               mem_ready;

  assign mem_ready = MEM_WAIT_EN ? mem_ready_ctl_i : 1'b1;

  mc_decode u_decode (
    .op       (instr_op_ctl_i),
    .funct    (instr_funct_ctl_i),
    .rt       (instr_rt_ctl_i),
    .cls      (cls),
    .alu_op   (dec_alu_op),
    .sign_ext (dec_sign_ext),
    .link     (dec_link),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    pc_wr_ctl_o      = 1'b0;
    ir_wr_ctl_o      = 1'b0;
    iord_ctl_o       = 1'b0;
    mem_read_ctl_o   = 1'b0;
    mem_wr_ctl_o     = 1'b0;
    alu_src_a_ctl_o  = 1'b0;
    alu_src_b_ctl_o  = SRC_B_REGB;
    alu_op_ctl_o     = ALU_ADD;
    sign_ext_ctl_o   = 1'b0;
    pc_src_ctl_o     = PC_SRC_ALU;
    branch_ctl_o     = 1'b0;
    reg_dst_ctl_o    = REG_DST_RT;
    mem_to_reg_ctl_o = M2R_ALU;
    reg_wr_ctl_o     = 1'b0;
    hilo_wr_ctl_o    = 1'b0;
    illegal_ctl_o    = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        mem_read_ctl_o  = 1'b1;
        alu_src_b_ctl_o = SRC_B_FOUR;
        if (mem_ready) begin
          ir_wr_ctl_o = 1'b1;
          pc_wr_ctl_o = 1'b1;
          state_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b_ctl_o = SRC_B_IMM_SH2;
        sign_ext_ctl_o  = 1'b1;
        if (dec_illegal) begin
          illegal_ctl_o = 1'b1;
          state_next    = ST_FETCH;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        case (cls)
          CLS_RALU: begin
            alu_src_a_ctl_o = 1'b1;
            alu_op_ctl_o    = dec_alu_op;
            state_next      = ST_WB;
          end
          CLS_IALU: begin
            alu_src_a_ctl_o = 1'b1;
            alu_src_b_ctl_o = SRC_B_IMM;
            alu_op_ctl_o    = dec_alu_op;
            sign_ext_ctl_o  = dec_sign_ext;
            state_next      = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_a_ctl_o = 1'b1;
            alu_src_b_ctl_o = SRC_B_IMM;
            sign_ext_ctl_o  = 1'b1;
            state_next      = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_src_a_ctl_o = 1'b1;
            alu_op_ctl_o    = ALU_SUB;
            branch_ctl_o    = 1'b1;
            pc_src_ctl_o    = PC_SRC_ALUOUT;
            if (dec_link) begin
              reg_dst_ctl_o    = REG_DST_RA;
              mem_to_reg_ctl_o = M2R_PC;
              reg_wr_ctl_o     = 1'b1;
            end
          end
          CLS_JUMP: begin
            pc_wr_ctl_o  = 1'b1;
            pc_src_ctl_o = PC_SRC_JUMP;
            if (dec_link) begin
              reg_dst_ctl_o    = REG_DST_RA;
              mem_to_reg_ctl_o = M2R_PC;
              reg_wr_ctl_o     = 1'b1;
            end
          end
          CLS_JR: begin
            pc_wr_ctl_o  = 1'b1;
            pc_src_ctl_o = PC_SRC_REGA;
            if (dec_link) begin
              reg_dst_ctl_o    = REG_DST_RD;
              mem_to_reg_ctl_o = M2R_PC;
              reg_wr_ctl_o     = 1'b1;
            end
          end
          CLS_MULDIV: begin
            cnt_next   = CNT_LOAD;
            state_next = ST_MULDIV;
          end
          CLS_MFHILO, CLS_MTHILO, CLS_SYSCALL: state_next = ST_WB;
          default: ;
        endcase
      end
      ST_MEM: begin
        iord_ctl_o     = 1'b1;
        mem_read_ctl_o = (cls == CLS_LOAD);
        mem_wr_ctl_o   = (cls == CLS_STORE);
        if (mem_ready) state_next = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        state_next = ST_FETCH;
        case (cls)
          CLS_RALU, CLS_MFHILO: begin
            reg_wr_ctl_o  = 1'b1;
            reg_dst_ctl_o = REG_DST_RD;
          end
          CLS_IALU: reg_wr_ctl_o = 1'b1;
          CLS_LOAD: begin
            reg_wr_ctl_o     = 1'b1;
            mem_to_reg_ctl_o = M2R_MEM;
          end
          CLS_MTHILO: hilo_wr_ctl_o = 1'b1;
          default: ;
        endcase
      end
      ST_MULDIV: begin
        if (cnt == '0) begin
          hilo_wr_ctl_o = 1'b1;
          state_next    = ST_FETCH;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign state_ctl_o = state;

endmodule
